// File: rtl/cdb_writeback_arbiter_pkg.sv
// Shared types and constants for the CDB writeback path.
package cdb_writeback_arbiter_pkg;

  localparam int unsigned NUM_FU_DEF     = 4;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned PHY_WIDTH_DEF  = 6;
  localparam int unsigned ROB_WIDTH_DEF  = 5;

  localparam int unsigned FU_ID_WIDTH = $clog2(NUM_FU_DEF);

  // Broadcast payload as seen by ROB, PRF write port and RS wakeup.
  typedef struct packed {
    logic [PHY_WIDTH_DEF-1:0]  prd;
    logic [DATA_WIDTH_DEF-1:0] data;
    logic [ROB_WIDTH_DEF-1:0]  rob_idx;
  } cdb_packet_t;

  // FU index width for an arbitrary FU count (never narrower than one bit).
  function automatic int unsigned fu_id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cdb_writeback_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned IDX_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [IDX_WIDTH-1:0] ptr_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic [IDX_WIDTH-1:0] grant_idx_o,
  output logic                 grant_any_o
);

  // Scan requests starting at ptr_i; the first hit wins.
  always_comb begin
    int unsigned cand;
    grant_o     = '0;
    grant_idx_o = '0;
    grant_any_o = 1'b0;
    cand        = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(ptr_i) + k) % NUM_REQ;
      if (!grant_any_o && req_i[cand]) begin
        grant_any_o   = 1'b1;
        grant_o[cand] = 1'b1;
        grant_idx_o   = IDX_WIDTH'(cand);
      end
    end
  end

endmodule

// File: rtl/cdb_writeback_arbiter.sv
// CDB writeback arbiter: one result slot per FU, round-robin grant,
// registered broadcast, flush kills everything in flight.
module cdb_writeback_arbiter
  import cdb_writeback_arbiter_pkg::*;
#(
  parameter int unsigned NUM_FU     = NUM_FU_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned PHY_WIDTH  = PHY_WIDTH_DEF,
  parameter int unsigned ROB_WIDTH  = ROB_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [NUM_FU-1:0]                fu_valid,
  output logic [NUM_FU-1:0]                fu_ready,
  input  logic [NUM_FU*PHY_WIDTH-1:0]      fu_prd,
  input  logic [NUM_FU*DATA_WIDTH-1:0]     fu_data,
  input  logic [NUM_FU*ROB_WIDTH-1:0]      fu_rob_idx,
  output logic                             cdb_valid,
  output logic [PHY_WIDTH-1:0]             cdb_prd,
  output logic [DATA_WIDTH-1:0]            cdb_data,
  output logic [ROB_WIDTH-1:0]             cdb_rob_idx,
  output logic [fu_id_width(NUM_FU)-1:0]   cdb_fu_id,
  output logic [31:0]                      conflict_cnt
);

  localparam int unsigned IDW = fu_id_width(NUM_FU);

  typedef struct packed {
    logic [PHY_WIDTH-1:0]  prd;
    logic [DATA_WIDTH-1:0] data;
    logic [ROB_WIDTH-1:0]  rob_idx;
  } pkt_t;

  logic [NUM_FU-1:0] slot_valid_q, slot_valid_d;
  pkt_t              slot_pkt_q [NUM_FU];
  pkt_t              slot_pkt_d [NUM_FU];
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic              cdb_valid_q, cdb_valid_d;
  pkt_t              cdb_pkt_q, cdb_pkt_d;
  logic [IDW-1:0]    cdb_id_q, cdb_id_d;
  logic [31:0]       conflict_q, conflict_d;

  logic [NUM_FU-1:0] req;
  logic [NUM_FU-1:0] grant;
  logic [NUM_FU-1:0] accept;
  logic [IDW-1:0]    grant_idx;
  logic              grant_any;

  assign req = flush ? '0 : slot_valid_q;

  rr_arbiter #(
    .NUM_REQ   (NUM_FU),
    .IDX_WIDTH (IDW)
  ) u_rr_arbiter (
    .req_i       (req),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_any_o (grant_any)
  );

  // A slot takes a new result when empty or when it is being drained this cycle.
  always_comb begin
    fu_ready = '0;
    if (!rst && !flush) fu_ready = ~slot_valid_q | grant;
    accept = fu_valid & fu_ready;
  end

  // Slot next state: refill wins over drain so a granted-and-refilled slot stays full.
  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_pkt_d   = slot_pkt_q;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (flush) begin
        slot_valid_d[i] = 1'b0;
      end else if (accept[i]) begin
        slot_valid_d[i] = 1'b1;
        slot_pkt_d[i]   = '{prd:     fu_prd[i*PHY_WIDTH +: PHY_WIDTH],
                            data:    fu_data[i*DATA_WIDTH +: DATA_WIDTH],
                            rob_idx: fu_rob_idx[i*ROB_WIDTH +: ROB_WIDTH]};
      end else if (grant[i]) begin
        slot_valid_d[i] = 1'b0;
      end
    end
  end

  // Broadcast register, round-robin pointer and conflict counter next state.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = grant_any;
    cdb_pkt_d   = cdb_pkt_q;
    cdb_id_d    = cdb_id_q;
    conflict_d  = conflict_q;
    if (grant_any) begin
      rr_ptr_d  = (grant_idx == IDW'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
      cdb_pkt_d = slot_pkt_q[grant_idx];
      cdb_id_d  = grant_idx;
    end
    if (!flush && ($countones(slot_valid_q) > 1) && (conflict_q != '1))
      conflict_d = conflict_q + 32'd1;
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid_q <= '0;
      slot_pkt_q   <= '{default: '0};
      rr_ptr_q     <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_pkt_q    <= '0;
      cdb_id_q     <= '0;
      conflict_q   <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_pkt_q   <= slot_pkt_d;
      rr_ptr_q     <= rr_ptr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_pkt_q    <= cdb_pkt_d;
      cdb_id_q     <= cdb_id_d;
      conflict_q   <= conflict_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_prd      = cdb_pkt_q.prd;
  assign cdb_data     = cdb_pkt_q.data;
  assign cdb_rob_idx  = cdb_pkt_q.rob_idx;
  assign cdb_fu_id    = cdb_id_q;
  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Self-checking bench for cdb_writeback_arbiter with a cycle-level reference model.
module tb_cdb_writeback_arbiter;

  localparam int N   = 4;
  localparam int D   = 32;
  localparam int P   = 6;
  localparam int R   = 5;
  localparam int IDW = 2;

  logic             clk, rst, flush;
  logic [N-1:0]     fu_valid, fu_ready;
  logic [N*P-1:0]   fu_prd;
  logic [N*D-1:0]   fu_data;
  logic [N*R-1:0]   fu_rob_idx;
  logic             cdb_valid;
  logic [P-1:0]     cdb_prd;
  logic [D-1:0]     cdb_data;
  logic [R-1:0]     cdb_rob_idx;
  logic [IDW-1:0]   cdb_fu_id;
  logic [31:0]      conflict_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  cdb_writeback_arbiter #(
    .NUM_FU     (N),
    .DATA_WIDTH (D),
    .PHY_WIDTH  (P),
    .ROB_WIDTH  (R)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .fu_valid     (fu_valid),
    .fu_ready     (fu_ready),
    .fu_prd       (fu_prd),
    .fu_data      (fu_data),
    .fu_rob_idx   (fu_rob_idx),
    .cdb_valid    (cdb_valid),
    .cdb_prd      (cdb_prd),
    .cdb_data     (cdb_data),
    .cdb_rob_idx  (cdb_rob_idx),
    .cdb_fu_id    (cdb_fu_id),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: result slots, pointer and broadcast as described by the rules.
  bit           m_sv [N];
  logic [P-1:0] m_prd [N];
  logic [D-1:0] m_data [N];
  logic [R-1:0] m_rob [N];
  int           m_ptr;
  bit           m_cv;
  logic [P-1:0] m_cprd;
  logic [D-1:0] m_cdata;
  logic [R-1:0] m_crob;
  int           m_cid;
  logic [31:0]  m_cnt;
  logic [N-1:0] exp_ready, act_ready, last_acc;

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_sv[i] = 0; m_prd[i] = '0; m_data[i] = '0; m_rob[i] = '0;
    end
    m_ptr = 0; m_cv = 0; m_cprd = '0; m_cdata = '0; m_crob = '0; m_cid = 0; m_cnt = '0;
  endtask

  task automatic set_fu(input int i, input logic [P-1:0] prd, input logic [D-1:0] data,
                        input logic [R-1:0] rob);
    fu_valid[i]          = 1'b1;
    fu_prd[i*P +: P]     = prd;
    fu_data[i*D +: D]    = data;
    fu_rob_idx[i*R +: R] = rob;
  endtask

  // One clock: sample ready before the edge, advance the model, land 1ns after the edge.
  task automatic tick();
    int g, nvalid, s;
    #1;
    act_ready = fu_ready;
    g = -1;
    nvalid = 0;
    for (int i = 0; i < N; i++) if (m_sv[i]) nvalid++;
    if (!flush)
      for (int k = 0; k < N; k++) begin
        s = (m_ptr + k) % N;
        if (g < 0 && m_sv[s]) g = s;
      end
    for (int i = 0; i < N; i++) exp_ready[i] = !flush && (!m_sv[i] || g == i);
    last_acc = fu_valid & exp_ready;
    if (!flush && nvalid > 1 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (g >= 0) begin
      m_cv = 1; m_cprd = m_prd[g]; m_cdata = m_data[g]; m_crob = m_rob[g]; m_cid = g;
      m_ptr = (g + 1) % N;
    end else begin
      m_cv = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (flush) m_sv[i] = 0;
      else if (last_acc[i]) begin
        m_sv[i] = 1; m_prd[i] = fu_prd[i*P +: P]; m_data[i] = fu_data[i*D +: D];
        m_rob[i] = fu_rob_idx[i*R +: R];
      end else if (g == i) m_sv[i] = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; fu_valid = '0; fu_prd = '0; fu_data = '0; fu_rob_idx = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; fu_valid = '1; fu_prd = '1; fu_data = '1; fu_rob_idx = '1;
    m_reset();
    repeat (2) @(posedge clk);
    #2;
    n_tests++;
    if (fu_ready !== 4'h0) begin
      n_fail++; $display("FAIL reset_ready got=%h exp=0", fu_ready);
    end
    n_tests++;
    if ({cdb_valid, cdb_prd, cdb_data, cdb_rob_idx, cdb_fu_id} !== '0) begin
      n_fail++; $display("FAIL reset_cdb got v=%b prd=%h data=%h rob=%h id=%h exp all 0",
                         cdb_valid, cdb_prd, cdb_data, cdb_rob_idx, cdb_fu_id);
    end
    n_tests++;
    if (conflict_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_conflict got=%0d exp=0", conflict_cnt);
    end
    fu_valid = '0;
    #1 rst = 1'b0;
    #1;
    n_tests++;
    if (fu_ready !== 4'hF) begin
      n_fail++; $display("FAIL release_ready got=%h exp=f", fu_ready);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_fu(2, 6'd9, 32'h1234, 5'd5);
    tick();
    fu_valid = '0;
    n_tests++;
    if (cdb_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_latency got=%b exp=0", cdb_valid);
    end
    tick();
    n_tests++;
    if ({cdb_valid, cdb_prd, cdb_data, cdb_rob_idx, cdb_fu_id} !== {1'b1, 6'd9, 32'h1234, 5'd5, 2'd2}) begin
      n_fail++; $display("FAIL single_bcast got v=%b prd=%0d data=%h rob=%0d id=%0d exp v=1 prd=9 data=1234 rob=5 id=2",
                         cdb_valid, cdb_prd, cdb_data, cdb_rob_idx, cdb_fu_id);
    end
    tick();
    n_tests++;
    if (cdb_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_drop got=%b exp=0", cdb_valid);
    end
  endtask

  task automatic test_all_four();
    do_reset();
    for (int i = 0; i < N; i++) set_fu(i, P'(i + 1), 32'h100 + 32'(i), R'(i));
    tick();
    fu_valid = '0;
    for (int k = 0; k < N; k++) begin
      tick();
      n_tests++;
      if (act_ready[3] !== (k == 3)) begin
        n_fail++; $display("FAIL all4_ready3 cyc=%0d got=%b exp=%b", k, act_ready[3], (k == 3));
      end
      n_tests++;
      if ({cdb_valid, cdb_fu_id, cdb_data} !== {1'b1, IDW'(k), 32'h100 + 32'(k)}) begin
        n_fail++; $display("FAIL all4_order cyc=%0d got v=%b id=%0d data=%h exp v=1 id=%0d data=%h",
                           k, cdb_valid, cdb_fu_id, cdb_data, k, 32'h100 + 32'(k));
      end
    end
    n_tests++;
    if (conflict_cnt !== 32'd3) begin
      n_fail++; $display("FAIL all4_conflict got=%0d exp=3", conflict_cnt);
    end
  endtask

  task automatic test_two_stream();
    logic [D-1:0] q0[$], q2[$], expd;
    logic [D-1:0] d0, d2;
    int prev_id, stall0, stall2, nb;
    do_reset();
    d0 = 32'h1000; d2 = 32'h2000; prev_id = -1; stall0 = 0; stall2 = 0; nb = 0;
    for (int c = 0; c < 24; c++) begin
      set_fu(0, 6'd1, d0, 5'd1);
      set_fu(2, 6'd3, d2, 5'd3);
      tick();
      if (last_acc[0]) begin q0.push_back(d0); d0++; stall0 = 0; end else stall0++;
      if (last_acc[2]) begin q2.push_back(d2); d2++; stall2 = 0; end else stall2++;
      n_tests++;
      if (stall0 > 1 || stall2 > 1) begin
        n_fail++; $display("FAIL stream_stall cyc=%0d got s0=%0d s2=%0d exp<=1", c, stall0, stall2);
      end
      if (cdb_valid === 1'b1) begin
        nb++;
        if (cdb_fu_id == 0 && q0.size() > 0) expd = q0.pop_front();
        else if (cdb_fu_id == 2 && q2.size() > 0) expd = q2.pop_front();
        else expd = 'x;
        n_tests++;
        if (cdb_data !== expd || int'(cdb_fu_id) == prev_id) begin
          n_fail++; $display("FAIL stream_seq cyc=%0d got id=%0d data=%h exp data=%h, id!=%0d",
                             c, cdb_fu_id, cdb_data, expd, prev_id);
        end
        prev_id = int'(cdb_fu_id);
      end
    end
    fu_valid = '0;
    n_tests++;
    if (nb != 23) begin
      n_fail++; $display("FAIL stream_rate got=%0d exp=23", nb);
    end
  endtask

  task automatic test_lone_stream();
    int k;
    do_reset();
    k = 1;
    for (int t = 1; t <= 12; t++) begin
      if (k <= 10) set_fu(1, 6'd7, 32'(k), 5'd2); else fu_valid = '0;
      tick();
      if (t <= 10) begin
        n_tests++;
        if (act_ready[1] !== 1'b1) begin
          n_fail++; $display("FAIL lone_ready t=%0d got=%b exp=1", t, act_ready[1]);
        end
      end
      if (last_acc[1]) k++;
      n_tests++;
      if (cdb_valid !== (t >= 2 && t <= 11) || (cdb_valid && cdb_data !== 32'(t - 1))) begin
        n_fail++; $display("FAIL lone_bcast t=%0d got v=%b data=%0d exp v=%b data=%0d",
                           t, cdb_valid, cdb_data, (t >= 2 && t <= 11), t - 1);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_fu(0, 6'd10, 32'hA0, 5'd0);
    set_fu(1, 6'd11, 32'hA1, 5'd1);
    set_fu(3, 6'd13, 32'hA3, 5'd3);
    tick();
    fu_valid = '0;
    flush = 1'b1;
    set_fu(2, 6'd12, 32'h77, 5'd2);
    tick();
    flush = 1'b0;
    fu_valid = '0;
    n_tests++;
    if (act_ready !== 4'h0 || cdb_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_cycle got ready=%h v=%b exp ready=0 v=0", act_ready, cdb_valid);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_tests++;
      if (cdb_valid !== 1'b0) begin
        n_fail++; $display("FAIL flush_stale cyc=%0d got v=%b id=%0d exp v=0", c, cdb_valid, cdb_fu_id);
      end
    end
    set_fu(3, 6'd30, 32'hBEEF, 5'd9);
    tick();
    fu_valid = '0;
    tick();
    n_tests++;
    if ({cdb_valid, cdb_fu_id, cdb_data, cdb_prd} !== {1'b1, 2'd3, 32'hBEEF, 6'd30}) begin
      n_fail++; $display("FAIL flush_after got v=%b id=%0d data=%h prd=%0d exp v=1 id=3 data=beef prd=30",
                         cdb_valid, cdb_fu_id, cdb_data, cdb_prd);
    end
    n_tests++;
    if (conflict_cnt !== 32'd0) begin
      n_fail++; $display("FAIL flush_conflict got=%0d exp=0", conflict_cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_fu(0, 6'd1, 32'h11, 5'd1);
    set_fu(1, 6'd2, 32'h22, 5'd2);
    set_fu(2, 6'd3, 32'h33, 5'd3);
    tick();
    fu_valid = '0;
    set_fu(0, 6'd4, 32'h44, 5'd4);
    tick();
    fu_valid = '0;
    n_tests++;
    if (cdb_valid !== 1'b1 || cdb_fu_id !== 2'd0) begin
      n_fail++; $display("FAIL arst_pre got v=%b id=%0d exp v=1 id=0", cdb_valid, cdb_fu_id);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (cdb_valid !== 1'b0 || fu_ready !== 4'h0 || conflict_cnt !== 32'd0) begin
      n_fail++; $display("FAIL arst_now got v=%b ready=%h cnt=%0d exp 0,0,0", cdb_valid, fu_ready, conflict_cnt);
    end
    m_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_tests++;
      if (cdb_valid !== 1'b0) begin
        n_fail++; $display("FAIL arst_quiet cyc=%0d got v=%b exp 0", c, cdb_valid);
      end
    end
    for (int i = 0; i < N; i++) set_fu(i, 6'd5, 32'h500 + 32'(i), 5'd5);
    tick();
    fu_valid = '0;
    for (int k = 0; k < N; k++) begin
      tick();
      n_tests++;
      if (cdb_valid !== 1'b1 || cdb_fu_id !== IDW'(k)) begin
        n_fail++; $display("FAIL arst_ptr cyc=%0d got v=%b id=%0d exp v=1 id=%0d", k, cdb_valid, cdb_fu_id, k);
      end
    end
    n_tests++;
    if (conflict_cnt !== 32'd3) begin
      n_fail++; $display("FAIL arst_conflict got=%0d exp=3", conflict_cnt);
    end
  endtask

  task automatic test_random();
    bit pend [N];
    do_reset();
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(2) != 0) begin
          pend[i] = 1;
          set_fu(i, P'($urandom), $urandom, R'($urandom));
        end
      flush = ($urandom_range(24) == 0);
      tick();
      for (int i = 0; i < N; i++)
        if (last_acc[i]) begin pend[i] = 0; fu_valid[i] = 1'b0; end
      n_tests++;
      if (act_ready !== exp_ready) begin
        n_fail++; $display("FAIL rnd_ready cyc=%0d got=%h exp=%h", c, act_ready, exp_ready);
      end
      n_tests++;
      if (cdb_valid !== m_cv) begin
        n_fail++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, cdb_valid, m_cv);
      end
      if (m_cv) begin
        n_tests++;
        if ({cdb_prd, cdb_data, cdb_rob_idx, cdb_fu_id} !== {m_cprd, m_cdata, m_crob, IDW'(m_cid)}) begin
          n_fail++; $display("FAIL rnd_payload cyc=%0d got prd=%h data=%h rob=%h id=%0d exp prd=%h data=%h rob=%h id=%0d",
                             c, cdb_prd, cdb_data, cdb_rob_idx, cdb_fu_id, m_cprd, m_cdata, m_crob, m_cid);
        end
      end
      n_tests++;
      if (conflict_cnt !== m_cnt) begin
        n_fail++; $display("FAIL rnd_conflict cyc=%0d got=%0d exp=%0d", c, conflict_cnt, m_cnt);
      end
    end
    flush = 1'b0;
    fu_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_two_stream();
    test_lone_stream();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
